// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the transaction FSM / coin hardware (master)
// and the change dispenser (slave).
interface change_dispenser_if;
  logic        start;
  logic [7:0]  change_money;
  logic [4:0]  coin_in;
  logic        refill;
  logic        eject_ack;
  logic        eject_valid;
  logic [4:0]  eject_sel;
  logic        busy;
  logic        done;
  logic        short;
  logic [7:0]  residual;
  logic [19:0] inv_count;

  modport slave (
    input  start, change_money, coin_in, refill, eject_ack,
    output eject_valid, eject_sel, busy, done, short, residual, inv_count
  );

  modport master (
    output start, change_money, coin_in, refill, eject_ack,
    input  eject_valid, eject_sel, busy, done, short, residual, inv_count
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout (largest coin first) over a valid/ack eject handshake, with per-coin inventory.
// Optional CHANGE_TIMEOUT_EN aborts a coin whose ack does not arrive within ACK_TIMEOUT cycles.
module change_dispenser #(
  parameter int COIN_INIT = 8
`ifdef CHANGE_TIMEOUT_EN
  , parameter int ACK_TIMEOUT = 1023
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  change_dispenser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SELECT, EJECT, DONE} state_t;

  localparam logic [4:0][7:0] DENOM    = {8'd50, 8'd20, 8'd10, 8'd5, 8'd1};
  localparam logic [3:0]      INIT_CNT = 4'(COIN_INIT);

  state_t          state_q, state_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [4:0][3:0] count_q, count_d;
  logic            eject_valid_q, eject_valid_d;
  logic [4:0]      eject_sel_q, eject_sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            short_q, short_d;
  logic [7:0]      residual_q, residual_d;

  logic [4:0] pick;
  logic [7:0] sel_val;
  logic       ack_take;
  logic [4:0] dec;
  logic       to_hit;

`ifdef CHANGE_TIMEOUT_EN
  localparam int              TO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign to_hit = (state_q == EJECT) && !bus.eject_ack && (to_cnt_q == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // Ascending scan so the largest qualifying denomination wins.
  always_comb begin : pick_logic
    pick    = '0;
    sel_val = '0;
    for (int i = 0; i < 5; i++) begin
      if (DENOM[i] <= remaining_q && count_q[i] != 4'd0) pick = 5'd1 << i;
      if (eject_sel_q[i]) sel_val = DENOM[i];
    end
  end

  assign ack_take = (state_q == EJECT) && bus.eject_ack;
  assign dec      = ack_take ? eject_sel_q : 5'd0;

  always_comb begin : next_state
    state_d       = state_q;
    remaining_d   = remaining_q;
    eject_valid_d = eject_valid_q;
    eject_sel_d   = eject_sel_q;
    done_d        = 1'b0;
    short_d       = short_q;
    residual_d    = residual_q;
`ifdef CHANGE_TIMEOUT_EN
    to_cnt_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          remaining_d = bus.change_money;
          short_d     = 1'b0;
          residual_d  = 8'd0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (remaining_q == 8'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (pick == 5'd0) begin
          state_d    = DONE;
          done_d     = 1'b1;
          short_d    = 1'b1;
          residual_d = remaining_q;
        end else begin
          state_d       = EJECT;
          eject_valid_d = 1'b1;
          eject_sel_d   = pick;
        end
      end
      EJECT: begin
        if (bus.eject_ack) begin
          state_d       = SELECT;
          remaining_d   = remaining_q - sel_val;
          eject_valid_d = 1'b0;
          eject_sel_d   = 5'd0;
        end else if (to_hit) begin
          // Abandoned coin is not dispensed: remaining and inventory untouched.
          state_d       = DONE;
          done_d        = 1'b1;
          short_d       = 1'b1;
          residual_d    = remaining_q;
          eject_valid_d = 1'b0;
          eject_sel_d   = 5'd0;
        end
`ifdef CHANGE_TIMEOUT_EN
        else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // A coin arriving in the same cycle as its denomination's eject cancels out.
  always_comb begin : inventory
    count_d = count_q;
    for (int i = 0; i < 5; i++) begin
      if (state_q == IDLE && bus.refill) begin
        count_d[i] = INIT_CNT;
      end else if (bus.coin_in[i] && !dec[i]) begin
        if (count_q[i] != 4'd15) count_d[i] = count_q[i] + 4'd1;
      end else if (dec[i] && !bus.coin_in[i]) begin
        count_d[i] = count_q[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      remaining_q   <= 8'd0;
      count_q       <= {5{INIT_CNT}};
      eject_valid_q <= 1'b0;
      eject_sel_q   <= 5'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      short_q       <= 1'b0;
      residual_q    <= 8'd0;
`ifdef CHANGE_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      count_q       <= count_d;
      eject_valid_q <= eject_valid_d;
      eject_sel_q   <= eject_sel_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      short_q       <= short_d;
      residual_q    <= residual_d;
`ifdef CHANGE_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

  assign bus.eject_valid = eject_valid_q;
  assign bus.eject_sel   = eject_sel_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.short       = short_q;
  assign bus.residual    = residual_q;
  assign bus.inv_count   = count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table of payouts scored against an eject scoreboard, plus reset/saturation/timeout sequences.
module tb_change_dispenser;
  localparam logic [4:0] C50 = 5'b10000;
  localparam logic [4:0] C20 = 5'b01000;
  localparam logic [4:0] C10 = 5'b00100;
  localparam logic [4:0] C5  = 5'b00010;
  localparam logic [4:0] C1  = 5'b00001;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  change_dispenser_if bus ();

  change_dispenser #(
    .COIN_INIT(8)
`ifdef CHANGE_TIMEOUT_EN
    , .ACK_TIMEOUT(16)
`endif
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic            refill;
    logic [7:0]      change;
    int              delay;
    logic            poke;
    int              n;
    logic [7:0][4:0] seq;
    logic            short_e;
    logic [7:0]      res;
    logic [19:0]     inv;
    int              lat;
  } vec_t;

  vec_t vt[9];

  function automatic vec_t mk(logic rf, logic [7:0] ch, int dl, logic pk, int n,
                              logic [39:0] sq, logic sh, logic [7:0] rs,
                              logic [19:0] iv, int lt);
    vec_t v;
    v.refill = rf; v.change = ch; v.delay = dl; v.poke = pk; v.n = n;
    v.seq = sq; v.short_e = sh; v.res = rs; v.inv = iv; v.lat = lt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [4:0] exp_q[$];
    int  k;
    int  wait_n;
    bit  got_done;
    int  done_k;
    wait_n   = 0;
    got_done = 1'b0;
    done_k   = 0;
    if (v.refill) begin
      bus.refill = 1'b1;
      tick();
      bus.refill = 1'b0;
    end
    for (int j = 0; j < v.n; j++) exp_q.push_back(v.seq[j]);
    bus.eject_ack    = (v.delay == 0);
    bus.change_money = v.change;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 1;
    check($sformatf("v%0d_busy_k1", idx), bus.busy, 1);
    check($sformatf("v%0d_short_clr", idx), bus.short, 0);
    check($sformatf("v%0d_res_clr", idx), bus.residual, 0);
    while (!got_done && k < 300) begin
      if (bus.done) begin
        got_done = 1'b1;
        done_k   = k;
      end else begin
        if (!bus.eject_valid) begin
          check($sformatf("v%0d_sel_idle", idx), bus.eject_sel, 0);
          wait_n = 0;
          if (v.delay != 0) bus.eject_ack = 1'b0;
        end else begin
          wait_n++;
          check($sformatf("v%0d_sb_nonempty", idx), exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            check($sformatf("v%0d_eject_sel", idx), bus.eject_sel, exp_q[0]);
            if (wait_n == v.delay + 1) begin
              bus.eject_ack = 1'b1;
              void'(exp_q.pop_front());
              wait_n = 0;
            end else if (v.delay != 0) begin
              bus.eject_ack = 1'b0;
            end
          end
        end
        if (v.poke) begin
          bus.start  = (k == 3);
          bus.refill = (k == 3);
          if (k == 3) bus.change_money = 8'd99;
        end
        tick();
        k++;
      end
    end
    check($sformatf("v%0d_done_seen", idx), got_done, 1);
    if (got_done) begin
      check($sformatf("v%0d_done_lat", idx), done_k, v.lat);
      check($sformatf("v%0d_busy_done", idx), bus.busy, 1);
      check($sformatf("v%0d_short", idx), bus.short, v.short_e);
      check($sformatf("v%0d_residual", idx), bus.residual, v.res);
      check($sformatf("v%0d_inv", idx), bus.inv_count, v.inv);
      check($sformatf("v%0d_sb_left", idx), exp_q.size(), 0);
    end
    bus.eject_ack = 1'b0;
    bus.start     = 1'b0;
    bus.refill    = 1'b0;
    tick();
    check($sformatf("v%0d_done_pulse", idx), bus.done, 0);
    check($sformatf("v%0d_busy_idle", idx), bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit got;

    vt[0] = mk(0, 8'd4,   0, 0, 4, {20'd0, C1, C1, C1, C1},            0, 8'd0, 20'h88884, 10);
    vt[1] = mk(0, 8'd4,   0, 0, 4, {20'd0, C1, C1, C1, C1},            0, 8'd0, 20'h88880, 10);
    vt[2] = mk(0, 8'd3,   0, 0, 0, 40'd0,                              1, 8'd3, 20'h88880, 2);
    vt[3] = mk(1, 8'd87,  0, 0, 6, {10'd0, C1, C1, C5, C10, C20, C50}, 0, 8'd0, 20'h77776, 14);
    vt[4] = mk(0, 8'd0,   0, 0, 0, 40'd0,                              0, 8'd0, 20'h77776, 2);
    vt[5] = mk(0, 8'd25,  5, 1, 2, {30'd0, C5, C20},                   0, 8'd0, 20'h76766, 16);
    vt[6] = mk(0, 8'd9,   1, 0, 5, {15'd0, C1, C1, C1, C1, C5},        0, 8'd0, 20'h76752, 17);
    vt[7] = mk(0, 8'd200, 0, 0, 4, {20'd0, C50, C50, C50, C50},        0, 8'd0, 20'h36752, 10);
    vt[8] = mk(0, 8'd4,   0, 0, 2, {30'd0, C1, C1},                    1, 8'd2, 20'h36750, 6);

    sys_rst          = 1'b1;
    bus.start        = 1'b0;
    bus.change_money = 8'd0;
    bus.coin_in      = 5'd0;
    bus.refill       = 1'b0;
    bus.eject_ack    = 1'b0;
    tick();
    tick();
    check("rst_valid", bus.eject_valid, 0);
    check("rst_sel", bus.eject_sel, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_short", bus.short, 0);
    check("rst_residual", bus.residual, 0);
    check("rst_inv", bus.inv_count, 20'h88888);
    sys_rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Saturation, then coin-in colliding with an eject of the same denomination.
    sys_rst = 1'b1;
    tick();
    sys_rst     = 1'b0;
    bus.coin_in = 5'b11111;
    repeat (10) tick();
    bus.coin_in = 5'd0;
    check("sat_inv", bus.inv_count, 20'hFFFFF);
    bus.change_money = 8'd1;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("sat_valid", bus.eject_valid, 1);
    check("sat_sel", bus.eject_sel, C1);
    bus.coin_in   = 5'b00001;
    bus.eject_ack = 1'b1;
    tick();
    bus.coin_in   = 5'd0;
    bus.eject_ack = 1'b0;
    check("sat_valid_drop", bus.eject_valid, 0);
    check("sat_collide_inv", bus.inv_count, 20'hFFFFF);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (bus.done) got = 1'b1;
      else tick();
    end
    check("sat_done_seen", got, 1);
    check("sat_short", bus.short, 0);
    tick();

    // Reset while a coin is presented and unacknowledged.
    bus.change_money = 8'd50;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("mid_valid", bus.eject_valid, 1);
    sys_rst = 1'b1;
    tick();
    check("mid_rst_valid", bus.eject_valid, 0);
    check("mid_rst_sel", bus.eject_sel, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_short", bus.short, 0);
    check("mid_rst_residual", bus.residual, 0);
    check("mid_rst_inv", bus.inv_count, 20'h88888);
    sys_rst = 1'b0;
    tick();
    check("mid_post_busy", bus.busy, 0);

    // Unacknowledged coin: aborts at the timeout, or waits forever without it.
    bus.change_money = 8'd50;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    k   = 1;
    got = 1'b0;
`ifdef CHANGE_TIMEOUT_EN
    while (!got && k < 100) begin
      if (bus.done) got = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    check("to_done_seen", got, 1);
    check("to_done_lat", k, 18);
    check("to_short", bus.short, 1);
    check("to_residual", bus.residual, 50);
    check("to_inv50", bus.inv_count[19:16], 8);
`else
    while (k < 40) begin
      if (bus.done) got = 1'b1;
      tick();
      k++;
    end
    check("wait_no_done", got, 0);
    check("wait_valid", bus.eject_valid, 1);
    check("wait_sel", bus.eject_sel, C50);
    check("wait_inv", bus.inv_count, 20'h88888);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequences the change-return mechanism of the vending machine. When the transaction FSM reports a change amount, this block pays it out one coin at a time, largest denomination first, from per-denomination coin inventories. It drives a valid/ack handshake toward the coin-eject actuator. It also tracks inventory from accepted (debounced) coin inputs. It sits between the transaction state machine and the eject hardware, and feeds the display path.

## Interface
- COIN_INIT, 8: inventory of each denomination after reset or refill; range 0..15.
- ACK_TIMEOUT, 1023: maximum cycles `eject_valid` may wait for `eject_ack`; used only with `CHANGE_TIMEOUT_EN`.

- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that latches `change_money`; honoured only in IDLE.
- change_money  in  8  amount to return, unsigned yuan.
- coin_in  in  5  one-hot-per-bit accepted-coin pulses, bit order {50,20,10,5,1} = [4:0]; several bits may be high together.
- refill  in  1  pulse; sets all inventories to COIN_INIT; honoured only in IDLE.
- eject_ack  in  1  actuator accepted the presented coin.
- eject_valid  out  1  coin request pending.
- eject_sel  out  5  one-hot denomination being ejected, same bit order as `coin_in`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a payout.
- short  out  1  last payout could not complete; held until next accepted `start`.
- residual  out  8  unpaid amount of last payout; held until next accepted `start`.
- inv_count  out  20  inventories, 4 bits each, [19:16]=50 … [3:0]=1.

## Operation
- States: IDLE, SELECT, EJECT, DONE.
- IDLE + start: remaining <= change_money; short <= 0; residual <= 0; go to SELECT.
- SELECT: pick the largest denomination d with d <= remaining and count(d) > 0.
  - If remaining == 0: go to DONE with short=0.
  - If no d qualifies: go to DONE with short=1 and residual=remaining.
  - Otherwise: latch eject_sel=d and go to EJECT.
- EJECT: eject_valid=1, eject_sel stable.
  - On eject_ack: remaining -= d, count(d) -= 1, eject_valid drops the next cycle, go to SELECT.
- DONE: done=1 for one cycle, then go to IDLE.
- Inventory update, every cycle in any state: count += coin_in bit, − ack-decrement.
  - Coin-in and decrement on the same denomination in the same cycle leaves the count unchanged.
  - Increments saturate at 15.
- `start` or `refill` while busy is ignored.
- `eject_ack` outside EJECT is ignored.
- Reset: state IDLE; eject_valid=0, eject_sel=0, busy=0, done=0, short=0, residual=0; all counts = COIN_INIT. Applies mid-payout with no coin completion.

## Timing
- `start` sampled at edge t: busy=1 from t+1 (SELECT). First eject_valid=1 at t+2.
- Per coin: 1 SELECT cycle + (1 + ack wait) EJECT cycles.
  - The ack is consumed in the same cycle it is seen with valid.
  - With eject_ack tied high, each coin costs 2 cycles.
- Count decrement and the remaining update are visible the cycle after the ack.
- done rises one cycle after the final SELECT. busy falls together with done's falling edge, i.e. IDLE follows DONE.
- change_money=0: done at t+2, no ejects.
- eject_sel is 0 whenever eject_valid=0.

## Configuration
- `CHANGE_TIMEOUT_EN` defined:
  - A counter runs while in EJECT without an ack.
  - When it reaches ACK_TIMEOUT, go to DONE with short=1 and residual=remaining. The pending coin is not counted as dispensed.
- `CHANGE_TIMEOUT_EN` undefined: EJECT waits for eject_ack indefinitely; no counter is synthesised.

## Test plan
- Reset, change_money=87, ack tied high → eject_sel sequence 50,20,10,5,1,1. Then done=1, short=0, residual=0, and inv_count = 7,7,7,7,6 (50,20,10,5,1).
- change_money=4 twice, then 3 → the two 4s eject 8 ones and leave the 1-coin count at 0. The 3 gives no eject_valid, done=1, short=1, residual=3.
- change_money=0 → done pulse exactly 2 cycles after start, no eject_valid, busy high for 2 cycles.
- Ack delayed 5 cycles per coin for change 25 → eject_valid/eject_sel stable while waiting. Output is 20 then 5, done at start+16.
- coin_in=5'b11111 pulsed 10 times from COIN_INIT=8 → all counts saturate at 15. With change 1 in EJECT, coin_in[0] and ack in the same cycle leave count(1)=15.
- With `CHANGE_TIMEOUT_EN`, ACK_TIMEOUT=16, no ack, change 50 → done at timeout, short=1, residual=50, count(50) unchanged. Separately, sys_rst asserted mid-EJECT → all outputs 0 and counts = COIN_INIT the next cycle.
